// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling and stop-bit check
//
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   rx_serial     asynchronous serial input, idle high
//   rx_byte       last correctly framed byte, held until the next good frame
//   data_valid    one-cycle pulse: rx_byte has just been updated
//   framing_error one-cycle pulse: stop bit sampled low, byte discarded
//   busy          high whenever the receiver is not idle

module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_serial,
  output logic [7:0] rx_byte,
  output logic       data_valid,
  output logic       framing_error,
  output logic       busy
);

  localparam int              HALF      = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_CLEAN
  } state_e;

  state_e           state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             prev_q, prev_d;
  logic [1:0]       settle_q, settle_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             data_valid_q, data_valid_d;
  logic             framing_error_q, framing_error_d;

  logic rx_s;
  logic settled;
  logic fall;

  assign rx_s = sync2_q;

  // The synchroniser and prev flops reset to 1, so for the first three
  // cycles after reset prev/rx_s still hold reset values rather than the
  // real line. A line held low across reset would otherwise look like a
  // falling edge once the low level reaches rx_s; edge detection is only
  // trusted once prev itself has been fed from the pin.
  assign settled = (settle_q == 2'd3);
  assign fall    = settled && prev_q && !rx_s;

  always_comb begin
    state_d         = state_q;
    sync1_d         = rx_serial;
    sync2_d         = sync1_q;
    prev_d          = sync2_q;
    settle_d        = settled ? settle_q : settle_q + 2'd1;
    cnt_d           = cnt_q;
    bit_idx_d       = bit_idx_q;
    shift_d         = shift_q;
    rx_byte_d       = rx_byte_q;
    data_valid_d    = 1'b0;
    framing_error_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        bit_idx_d = 3'd0;
        if (fall) begin
          state_d = S_START;
        end
      end

      S_START: begin
        // Mid-point of the start bit: a high line here means the edge was
        // a glitch, so drop back to idle without reporting anything.
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d            = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            rx_byte_d    = shift_q;
            data_valid_d = 1'b1;
          end else begin
            framing_error_d = 1'b1;
          end
          state_d = S_CLEAN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // One cycle in which the result pulse is visible; leaving here about
      // half a bit before the stop bit ends lets a directly following start
      // edge be seen from IDLE.
      S_CLEAN: begin
        cnt_d     = '0;
        bit_idx_d = 3'd0;
        state_d   = S_IDLE;
      end

      default: begin
        cnt_d     = '0;
        bit_idx_d = 3'd0;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      sync1_q         <= 1'b1;
      sync2_q         <= 1'b1;
      prev_q          <= 1'b1;
      settle_q        <= 2'd0;
      cnt_q           <= '0;
      bit_idx_q       <= 3'd0;
      shift_q         <= 8'h00;
      rx_byte_q       <= 8'h00;
      data_valid_q    <= 1'b0;
      framing_error_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      sync1_q         <= sync1_d;
      sync2_q         <= sync2_d;
      prev_q          <= prev_d;
      settle_q        <= settle_d;
      cnt_q           <= cnt_d;
      bit_idx_q       <= bit_idx_d;
      shift_q         <= shift_d;
      rx_byte_q       <= rx_byte_d;
      data_valid_q    <= data_valid_d;
      framing_error_q <= framing_error_d;
    end
  end

  assign rx_byte       = rx_byte_q;
  assign data_valid    = data_valid_q;
  assign framing_error = framing_error_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx

module tb_uart_rx;

  localparam int CPB    = 16;
  localparam int HALF   = CPB / 2;
  // pin edge -> detected edge is 2 clk; pulse follows stop-bit sample by 1
  localparam int DV_LAT = 2 + HALF + 9 * CPB + 1;

  logic       clk;
  logic       rst;
  logic       rx_serial;
  logic [7:0] rx_byte;
  logic       data_valid;
  logic       framing_error;
  logic       busy;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_serial     (rx_serial),
    .rx_byte       (rx_byte),
    .data_valid    (data_valid),
    .framing_error (framing_error),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         cyc;
    bit         good;
    logic [7:0] b;
  } ev_t;

  ev_t act_q[$];
  ev_t exp_q[$];
  int  dv_cnt;
  int  fe_cnt;
  int  dv_cyc;

  always @(negedge clk) begin
    if (!rst && (data_valid || framing_error)) begin
      ev_t e;
      e.cyc  = cyc;
      e.good = data_valid;
      e.b    = rx_byte;
      act_q.push_back(e);
      if (data_valid) begin
        dv_cnt++;
        dv_cyc = cyc;
      end
      if (framing_error) fe_cnt++;
      checks++;
      if (data_valid && framing_error) begin
        errors++;
        $display("FAIL pulse_exclusive: data_valid and framing_error both high at cycle %0d", cyc);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives start, 8 data bits LSB first and the stop bit; the line is left
  // at the stop level.
  task automatic drive_frame(input logic [7:0] b, input bit stop_bit, output int t_start);
    @(negedge clk);
    rx_serial = 1'b0;
    t_start   = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_serial = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_serial = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_bit, input int gap, output int t_start);
    drive_frame(b, stop_bit, t_start);
    rx_serial = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic clear_counts();
    dv_cnt = 0;
    fe_cnt = 0;
    dv_cyc = -1;
  endtask

  typedef struct {
    logic [7:0] data;
    bit         stop;
    int         gap;
    int         exp_dv;
    int         exp_fe;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t vecs[8];

  initial begin : main
    int t;
    logic [7:0] last_good;

    vecs[0] = '{8'hA5, 1'b1, 20, 1, 0, 8'hA5};
    vecs[1] = '{8'h3C, 1'b0, 20, 0, 1, 8'hA5};
    vecs[2] = '{8'h00, 1'b1, 0,  1, 0, 8'h00};
    vecs[3] = '{8'hFF, 1'b1, 20, 1, 0, 8'hFF};
    vecs[4] = '{8'h55, 1'b1, 0,  1, 0, 8'h55};
    vecs[5] = '{8'h80, 1'b1, 0,  1, 0, 8'h80};
    vecs[6] = '{8'h01, 1'b0, 5,  0, 1, 8'h80};
    vecs[7] = '{8'h7E, 1'b1, 10, 1, 0, 8'h7E};

    rst       = 1'b1;
    rx_serial = 1'b1;
    clear_counts();
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_rx_byte", rx_byte, 8'h00);
    chk("reset_data_valid", data_valid, 0);
    chk("reset_framing_error", framing_error, 0);
    chk("reset_busy", busy, 0);
    repeat (5) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      clear_counts();
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].gap, t);
      chk($sformatf("vec%0d_dv_count", i), dv_cnt, vecs[i].exp_dv);
      chk($sformatf("vec%0d_fe_count", i), fe_cnt, vecs[i].exp_fe);
      chk($sformatf("vec%0d_rx_byte", i), rx_byte, vecs[i].exp_byte);
      chk($sformatf("vec%0d_busy_idle", i), busy, 0);
      if (vecs[i].exp_dv == 1)
        chk($sformatf("vec%0d_dv_timing", i), dv_cyc, t + DV_LAT);
    end

    // Short glitch: 4 clk low, rejected at the start-bit midpoint.
    clear_counts();
    @(negedge clk);
    rx_serial = 1'b0;
    t = cyc;
    repeat (4) @(negedge clk);
    rx_serial = 1'b1;
    while (cyc < t + 2 + HALF) @(negedge clk);
    chk("glitch_busy_before_reject", busy, 1);
    @(negedge clk);
    chk("glitch_busy_after_reject", busy, 0);
    repeat (40) @(negedge clk);
    chk("glitch_dv_count", dv_cnt, 0);
    chk("glitch_fe_count", fe_cnt, 0);
    chk("glitch_rx_byte", rx_byte, 8'h7E);

    // Framing error followed by a held-low break line.
    clear_counts();
    drive_frame(8'hC3, 1'b0, t);
    repeat (100) @(negedge clk);
    chk("break_fe_count", fe_cnt, 1);
    chk("break_dv_count", dv_cnt, 0);
    chk("break_busy", busy, 0);
    chk("break_rx_byte", rx_byte, 8'h7E);
    rx_serial = 1'b1;
    repeat (20) @(negedge clk);
    clear_counts();
    send_frame(8'h99, 1'b1, 10, t);
    chk("after_break_dv_count", dv_cnt, 1);
    chk("after_break_rx_byte", rx_byte, 8'h99);

    // Reset during data bit 4 of 0x5A, then a normal frame.
    clear_counts();
    @(negedge clk);
    rx_serial = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_serial = (8'h5A >> i) & 1;
      repeat (CPB) @(negedge clk);
    end
    rx_serial = 1'b1;
    repeat (HALF) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midreset_rx_byte", rx_byte, 8'h00);
    chk("midreset_busy", busy, 0);
    chk("midreset_data_valid", data_valid, 0);
    repeat (200) @(negedge clk);
    chk("midreset_dv_count", dv_cnt, 0);
    chk("midreset_fe_count", fe_cnt, 0);
    send_frame(8'h81, 1'b1, 10, t);
    chk("midreset_0x81_dv_count", dv_cnt, 1);
    chk("midreset_0x81_rx_byte", rx_byte, 8'h81);
    chk("midreset_0x81_timing", dv_cyc, t + DV_LAT);

    // Line held low across reset release.
    clear_counts();
    rst       = 1'b1;
    rx_serial = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    chk("heldlow_busy", busy, 0);
    chk("heldlow_dv_count", dv_cnt, 0);
    chk("heldlow_fe_count", fe_cnt, 0);
    rx_serial = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(8'h42, 1'b1, 10, t);
    chk("heldlow_0x42_dv_count", dv_cnt, 1);
    chk("heldlow_0x42_rx_byte", rx_byte, 8'h42);
    chk("heldlow_0x42_timing", dv_cyc, t + DV_LAT);

    // Random frames against an event-list model.
    act_q.delete();
    exp_q.delete();
    last_good = 8'h42;
    begin
      bit prev_bad = 1'b0;
      for (int i = 0; i < 20; i++) begin
        logic [7:0] b;
        bit         stop_bit;
        int         gap;
        ev_t        e;
        b        = 8'($urandom);
        stop_bit = ($urandom_range(0, 5) != 0);
        gap      = $urandom_range(0, 30);
        if (!stop_bit && gap < 2) gap = 2;
        prev_bad = !stop_bit;
        send_frame(b, stop_bit, gap, t);
        if (stop_bit) last_good = b;
        e.cyc  = t + DV_LAT;
        e.good = stop_bit;
        e.b    = last_good;
        exp_q.push_back(e);
      end
      if (prev_bad) repeat (2) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    chk("rand_event_count", act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      chk($sformatf("rand%0d_cycle", i), act_q[i].cyc, exp_q[i].cyc);
      chk($sformatf("rand%0d_kind", i), act_q[i].good, exp_q[i].good);
      chk($sformatf("rand%0d_byte", i), act_q[i].b, exp_q[i].b);
    end
    chk("rand_final_rx_byte", rx_byte, last_good);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: the receive-side counterpart of the team's uart_tx.
- Deserialises an 8N1 asynchronous stream (1 start bit, 8 data bits LSB first, 1 stop bit, idle high) into bytes.
- Samples each bit at mid-bit using a baud counter and checks the stop bit.
- Feeds received bytes to the hangman game logic; validity is signalled by a one-cycle strobe.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per serial bit; legal range ≥ 4. HALF = CLKS_PER_BIT/2 (integer floor).
- CNT_W, $clog2(CLKS_PER_BIT): width of the baud counter. Derived; not overridden.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- rx_serial  in  1  asynchronous serial line; idle high.
- rx_byte  out  8  last correctly framed byte; held until the next good frame.
- data_valid  out  1  one-cycle pulse: rx_byte has just been updated.
- framing_error  out  1  one-cycle pulse: stop bit sampled low, byte discarded.
- busy  out  1  high whenever state is not IDLE.

Interface: one clock; reset is synchronous and active-high.

Behaviour:
- **Synchroniser**
  - rx_serial passes through a 2-flop synchroniser; both flops reset to 1.
  - A third registered copy (prev) provides edge detection.
  - All logic below uses the synchronised signal, rx_s.
- **Reset**
  - Applies on any clk edge with rst=1, including mid-frame.
  - rx_byte=8'h00, data_valid=0, framing_error=0, busy=0.
  - State=IDLE; counter, bit_index and shift register cleared.
- **States:** IDLE, START, DATA, STOP, CLEAN.
- **IDLE**
  - Counter=0, bit_index=0.
  - Go to START only on the falling edge prev=1 && rx_s=0.
  - A line already low when reset releases does not start a frame.
- **START**
  - Counter increments each cycle.
  - When counter==HALF-1, sample rx_s and clear the counter.
  - If rx_s=0, go to DATA.
  - If rx_s=1, treat it as a glitch: return to IDLE with no outputs asserted.
- **DATA**
  - Counter increments each cycle.
  - When counter==CLKS_PER_BIT-1, shift rx_s into bit position bit_index (LSB first) and clear the counter.
  - If bit_index==7, go to STOP; otherwise increment bit_index.
- **STOP**
  - When counter==CLKS_PER_BIT-1, sample rx_s.
  - If rx_s=1: load rx_byte from the shift register and set data_valid for the next cycle.
  - If rx_s=0: set framing_error for the next cycle and leave rx_byte unchanged.
  - Go to CLEAN.
- **CLEAN**
  - Lasts exactly one cycle, during which the data_valid or framing_error pulse is high.
  - Then return to IDLE.
  - data_valid and framing_error are never high together, and never high for more than one cycle per frame.
- **Timing**
  - Let T0 be the cycle in which the falling edge is detected on rx_s (2–3 clk after the pin edge).
  - Start bit sampled at T0+HALF.
  - Data bit k sampled at T0+HALF+(k+1)·CLKS_PER_BIT.
  - Stop bit sampled at T0+HALF+9·CLKS_PER_BIT.
  - data_valid high in cycle T0+HALF+9·CLKS_PER_BIT+1.
- **Back-to-back frames**
  - The return to IDLE occurs about half a bit before the stop bit ends.
  - A start edge immediately following the stop bit is therefore caught without loss.
- **Framing error followed by break**
  - After a framing error the line may remain low.
  - No new frame starts until rx_s returns high and falls again.
- **Line changes outside sample points** are ignored, apart from the IDLE edge detect.
- **busy** is combinational from state: it is 0 only in IDLE.

Test Plan (CLKS_PER_BIT=16, HALF=8):
- Send 0xA5 as a clean 8N1 frame at 16 clk/bit -> rx_byte=0xA5; data_valid high for exactly 1 cycle at T0+8+144+1; framing_error stays 0; busy returns to 0.
- Drive rx_serial low for 4 clk, then high -> START rejects it at T0+8; no data_valid, no framing_error; rx_byte unchanged; busy falls after about 9 cycles.
- Send 0xA5, then 0x3C with stop bit=0 -> framing_error pulses 1 cycle; rx_byte still 0xA5; data_valid does not fire for the second frame.
- Send 0x00 and 0xFF back-to-back with no idle gap -> two data_valid pulses; rx_byte reads 0x00, then 0xFF.
- Assert rst for 1 cycle during DATA bit 4 of 0x5A, then send 0x81 -> outputs return to reset values (rx_byte=0x00); no pulse from the aborted frame; 0x81 is then received correctly.
- Hold rx_serial low across reset release, then raise it, then send 0x42 -> no frame while held low; 0x42 received with a single data_valid.
